// File: rtl/mult_operand_sequencer_pkg.sv
// Shared constants and FSM encoding for the multiplier operand sequencer
// and its sibling sequencer stages.
package mult_operand_sequencer_pkg;

  localparam int unsigned DEF_DATA    = 256;
  localparam int unsigned DEF_ADDR    = 2;
  localparam int unsigned DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_START,
    ST_WAIT,
    ST_WR
  } seq_state_e;

endpackage

// File: rtl/mult_operand_sequencer_if.sv
// Command, dual-port RAM, multiplier and status bundle of the operand sequencer.
// The master modport is the sequencer side.
interface mult_operand_sequencer_if
  import mult_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA = DEF_DATA,
  parameter int unsigned ADDR = DEF_ADDR
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [ADDR-1:0] cmd_src_a;
  logic [ADDR-1:0] cmd_src_b;
  logic [ADDR-1:0] cmd_dst;

  logic            ram_a_w;
  logic [ADDR-1:0] ram_a_adbus;
  logic [DATA-1:0] ram_a_data_in;
  logic [DATA-1:0] ram_a_data_out;
  logic            ram_b_w;
  logic [ADDR-1:0] ram_b_adbus;
  logic [DATA-1:0] ram_b_data_in;
  logic [DATA-1:0] ram_b_data_out;

  logic            mul_start;
  logic [DATA-1:0] mul_op_a;
  logic [DATA-1:0] mul_op_b;
  logic            mul_done;
  logic [DATA-1:0] mul_result;

  logic            busy;
  logic            done;
  logic            err;

  modport master (
    input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
    input  ram_a_data_out, ram_b_data_out, mul_done, mul_result,
    output cmd_ready, ram_a_w, ram_a_adbus, ram_a_data_in,
    output ram_b_w, ram_b_adbus, ram_b_data_in,
    output mul_start, mul_op_a, mul_op_b, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
    output ram_a_data_out, ram_b_data_out, mul_done, mul_result,
    input  cmd_ready, ram_a_w, ram_a_adbus, ram_a_data_in,
    input  ram_b_w, ram_b_adbus, ram_b_data_in,
    input  mul_start, mul_op_a, mul_op_b, busy, done, err
  );

endinterface

// File: rtl/seq_timeout_ctr.sv
// Loadable down-counter used by the sequencer stages to bound handshake waits.
// expired_o is high while the count sits at zero.
module seq_timeout_ctr #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mult_operand_sequencer.sv
// Reads two operands from the dual-port RAM, runs one field multiplication
// through the start/done handshake and writes the product back via port A.
module mult_operand_sequencer
  import mult_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA    = DEF_DATA,
  parameter int unsigned ADDR    = DEF_ADDR,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic                      clk,
  input logic                      rst,
  mult_operand_sequencer_if.master bus
);

  seq_state_e      state_q, state_d;
  logic [ADDR-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [DATA-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic            err_q, err_d, done_q, done_d;
  logic            tmo_load, tmo_dec, tmo_expired;

  logic            cmd_ready, ram_a_w, mul_start;
  logic [ADDR-1:0] ram_a_adbus, ram_b_adbus;
  logic [DATA-1:0] ram_a_data_in;

  seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmo_load),
    .dec_i     (tmo_dec),
    .expired_o (tmo_expired)
  );

  // Addresses and write data are gated by state so every idle output reads zero.
  always_comb begin
    state_d       = state_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    dst_d         = dst_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    res_d         = res_q;
    err_d         = err_q;
    done_d        = 1'b0;
    tmo_load      = 1'b0;
    tmo_dec       = 1'b0;
    cmd_ready     = 1'b0;
    ram_a_w       = 1'b0;
    ram_a_adbus   = '0;
    ram_b_adbus   = '0;
    ram_a_data_in = '0;
    mul_start     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          src_a_d = bus.cmd_src_a;
          src_b_d = bus.cmd_src_b;
          dst_d   = bus.cmd_dst;
          err_d   = 1'b0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        ram_a_adbus = src_a_q;
        ram_b_adbus = src_b_q;
        state_d     = ST_CAP;
      end
      ST_CAP: begin
        op_a_d  = bus.ram_a_data_out;
        op_b_d  = bus.ram_b_data_out;
        state_d = ST_START;
      end
      ST_START: begin
        mul_start = 1'b1;
        tmo_load  = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mul_done) begin
          res_d   = bus.mul_result;
          state_d = ST_WR;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_WR: begin
        ram_a_w       = 1'b1;
        ram_a_adbus   = dst_q;
        ram_a_data_in = res_q;
        done_d        = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q   <= dst_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.ram_a_w       = ram_a_w;
  assign bus.ram_a_adbus   = ram_a_adbus;
  assign bus.ram_a_data_in = ram_a_data_in;
  assign bus.ram_b_w       = 1'b0;
  assign bus.ram_b_adbus   = ram_b_adbus;
  assign bus.ram_b_data_in = '0;
  assign bus.mul_start     = mul_start;
  assign bus.mul_op_a      = op_a_q;
  assign bus.mul_op_b      = op_b_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = done_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Bench for mult_operand_sequencer: RAM and multiplier models around the DUT,
// expectations derived from the command-level timing and dataflow rules.
module tb_mult_operand_sequencer;
  import mult_operand_sequencer_pkg::*;

  localparam int unsigned DW = DEF_DATA;
  localparam int unsigned AW = DEF_ADDR;
  localparam int          TO = 8;

  typedef logic [DW-1:0] word_t;
  typedef struct { int cyc; int addr; word_t data; } wr_t;
  typedef struct { int sa; int sb; int d; int lat; bit stray; bit exp_tmo; } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_operand_sequencer_if #(.DATA(DW), .ADDR(AW)) bus ();

  mult_operand_sequencer #(.DATA(DW), .ADDR(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  word_t ram [4];
  word_t ref_mem [4];

  int    lat_cfg   = 0;
  bit    stray_arm = 1'b0;
  int    acc_log[$], st_log[$], done_log[$], err_log[$];
  wr_t   wr_log[$];
  int    hold_bad  = 0;

  function automatic word_t mul_model(input word_t a, input word_t b);
    return a * b;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk_w(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ram(input string tag);
    for (int i = 0; i < 4; i++) chk_w($sformatf("%s_ram%0d", tag, i), ram[i], ref_mem[i]);
  endtask

  // Environment: registered-read dual-port RAM, multiplier with configurable
  // latency (0 = never answers) and an optional stray done in the START cycle.
  initial begin : env
    logic [AW-1:0] sa_addr, sb_addr;
    logic          sw;
    word_t         swd, st_a, st_b, pend_res;
    bit            pend, inflight, err_prev;
    int            pend_cyc, stray_cyc;
    pend = 0; inflight = 0; err_prev = 0; stray_cyc = -1; pend_cyc = 0;
    st_a = '0; st_b = '0; pend_res = '0;
    bus.ram_a_data_out = '0;
    bus.ram_b_data_out = '0;
    bus.mul_done       = 1'b0;
    bus.mul_result     = '0;
    forever begin
      @(negedge clk);
      sa_addr = bus.ram_a_adbus;
      sb_addr = bus.ram_b_adbus;
      sw      = bus.ram_a_w;
      swd     = bus.ram_a_data_in;
      if (!rst && bus.cmd_valid && bus.cmd_ready) begin
        acc_log.push_back(cyc);
        if (stray_arm) stray_cyc = cyc + 3;
      end
      if (inflight && (bus.mul_op_a !== st_a || bus.mul_op_b !== st_b)) hold_bad++;
      if (bus.mul_start) begin
        st_log.push_back(cyc);
        st_a = bus.mul_op_a;
        st_b = bus.mul_op_b;
        inflight = 1;
        pend = 0;
        if (lat_cfg > 0) begin
          pend     = 1;
          pend_cyc = cyc + lat_cfg;
          pend_res = mul_model(bus.mul_op_a, bus.mul_op_b);
        end
      end
      if (sw) begin
        wr_log.push_back('{cyc, int'(sa_addr), swd});
        inflight = 0;
      end
      if (!bus.busy) inflight = 0;
      if (bus.done) done_log.push_back(cyc);
      if (bus.err && !err_prev) err_log.push_back(cyc);
      err_prev = bus.err;
      @(posedge clk);
      cyc++;
      #1;
      bus.ram_a_data_out = ram[sa_addr];
      bus.ram_b_data_out = ram[sb_addr];
      if (sw) ram[sa_addr] = swd;
      bus.mul_done   = 1'b0;
      bus.mul_result = '0;
      if (pend && cyc == pend_cyc) begin
        bus.mul_done   = 1'b1;
        bus.mul_result = pend_res;
        pend = 0;
      end else if (cyc == stray_cyc) begin
        bus.mul_done   = 1'b1;
        bus.mul_result = {8{32'hDEADBEEF}};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_cmd(input string tag, input int sa, input int sb, input int d,
                         input int lat, input bit stray, input bit exp_tmo);
    int a0, s0, w0, d0, e0, h0, t_acc, s_cyc;
    bit got;
    word_t pa, pb, prod;
    pa = ref_mem[sa];
    pb = ref_mem[sb];
    prod = mul_model(pa, pb);
    a0 = acc_log.size(); s0 = st_log.size(); w0 = wr_log.size();
    d0 = done_log.size(); e0 = err_log.size(); h0 = hold_bad;
    lat_cfg = lat;
    stray_arm = stray;
    bus.cmd_src_a = AW'(sa);
    bus.cmd_src_b = AW'(sb);
    bus.cmd_dst   = AW'(d);
    bus.cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = acc_log.size() > a0;
    end
    bus.cmd_valid = 1'b0;
    stray_arm = 1'b0;
    chk_i({tag, "_accepted"}, int'(got), 1);
    if (!got) return;
    chk_i({tag, "_err_cleared"}, int'(bus.err), 0);
    t_acc = acc_log[a0];
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = (done_log.size() > d0) || (err_log.size() > e0);
    end
    chk_i({tag, "_completed"}, int'(got), 1);
    if (!got) return;
    step();
    chk_i({tag, "_starts"}, st_log.size() - s0, 1);
    if (st_log.size() != s0 + 1) return;
    s_cyc = st_log[s0];
    chk_i({tag, "_start_cyc"}, s_cyc, t_acc + 3);
    chk_i({tag, "_op_hold"}, hold_bad - h0, 0);
    if (!exp_tmo) begin
      chk_i({tag, "_writes"}, wr_log.size() - w0, 1);
      chk_i({tag, "_dones"}, done_log.size() - d0, 1);
      if (wr_log.size() == w0 + 1 && done_log.size() == d0 + 1) begin
        chk_i({tag, "_wr_cyc"}, wr_log[w0].cyc, s_cyc + lat + 1);
        chk_i({tag, "_wr_addr"}, wr_log[w0].addr, d);
        chk_w({tag, "_wr_data"}, wr_log[w0].data, prod);
        chk_i({tag, "_done_cyc"}, done_log[d0], s_cyc + lat + 2);
      end
      chk_i({tag, "_err"}, int'(bus.err), 0);
      ref_mem[d] = prod;
    end else begin
      chk_i({tag, "_tmo_writes"}, wr_log.size() - w0, 0);
      chk_i({tag, "_tmo_dones"}, done_log.size() - d0, 0);
      if (err_log.size() > e0) chk_i({tag, "_err_cyc"}, err_log[e0], s_cyc + TO + 1);
      chk_i({tag, "_tmo_err"}, int'(bus.err), 1);
    end
    chk_i({tag, "_idle"}, int'(bus.busy), 0);
    chk_ram(tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t  vecs [6];
    word_t p1, p2, sq;
    int    a0, d0, w0, s0, sa, sb, d, lat, k;
    bit    got, stray;

    vecs[0] = '{1, 2, 3, 4, 1'b0, 1'b0};  // 5*7 -> RAM[3]
    vecs[1] = '{0, 3, 1, 1, 1'b0, 1'b0};  // minimum multiplier latency
    vecs[2] = '{3, 1, 0, TO, 1'b0, 1'b0}; // done in the last waiting cycle
    vecs[3] = '{0, 0, 2, TO + 1, 1'b0, 1'b1};
    vecs[4] = '{1, 2, 0, 0, 1'b0, 1'b1};  // multiplier never answers
    vecs[5] = '{2, 1, 3, 3, 1'b1, 1'b0};  // early done in START is ignored

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src_a = '0;
    bus.cmd_src_b = '0;
    bus.cmd_dst   = '0;
    ram[0] = word_t'(3); ram[1] = word_t'(5); ram[2] = word_t'(7); ram[3] = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = ram[i];
    repeat (3) step();
    chk_i("rst_ready", int'(bus.cmd_ready), 1);
    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_flags", int'({bus.done, bus.err, bus.mul_start, bus.ram_a_w, bus.ram_b_w}), 0);
    chk_w("rst_op_a", bus.mul_op_a, '0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].sa, vecs[i].sb, vecs[i].d,
              vecs[i].lat, vecs[i].stray, vecs[i].exp_tmo);
      if (i == 0) chk_w("vec0_ram3_is_35", ram[3], word_t'(35));
    end

    // Squaring in place: same word on both ports, written back over itself.
    sq = '0;
    sq[DW-1] = 1'b1;
    sq = sq - word_t'(19);
    ram[2] = sq;
    ref_mem[2] = sq;
    run_cmd("square", 2, 2, 2, 5, 1'b0, 1'b0);
    chk_w("square_result", ram[2], mul_model(sq, sq));

    // Back-to-back with cmd_valid held: second accept lands on the first done.
    p1 = mul_model(ref_mem[0], ref_mem[1]);
    p2 = mul_model(p1, p1);
    a0 = acc_log.size(); d0 = done_log.size(); w0 = wr_log.size();
    lat_cfg = 2;
    bus.cmd_src_a = 2'd0; bus.cmd_src_b = 2'd1; bus.cmd_dst = 2'd2;
    bus.cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin step(); got = acc_log.size() > a0; end
    bus.cmd_src_a = 2'd2; bus.cmd_src_b = 2'd2; bus.cmd_dst = 2'd3;
    for (int i = 0; i < 40 && got && acc_log.size() < a0 + 2; i++) step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 40 && done_log.size() < d0 + 2; i++) step();
    step();
    chk_i("b2b_accepts", acc_log.size() - a0, 2);
    chk_i("b2b_dones", done_log.size() - d0, 2);
    chk_i("b2b_writes", wr_log.size() - w0, 2);
    if (acc_log.size() == a0 + 2 && done_log.size() == d0 + 2 && wr_log.size() == w0 + 2) begin
      chk_i("b2b_second_accept_cyc", acc_log[a0 + 1], done_log[d0]);
      chk_w("b2b_first_data", wr_log[w0].data, p1);
      chk_w("b2b_second_data", wr_log[w0 + 1].data, p2);
    end
    ref_mem[2] = p1;
    ref_mem[3] = p2;
    chk_ram("b2b");

    // Reset in WAIT, then the abandoned multiplication answers two cycles later.
    a0 = acc_log.size(); d0 = done_log.size(); w0 = wr_log.size(); s0 = st_log.size();
    lat_cfg = 5;
    bus.cmd_src_a = 2'd1; bus.cmd_src_b = 2'd2; bus.cmd_dst = 2'd0;
    bus.cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin step(); got = acc_log.size() > a0; end
    bus.cmd_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin step(); got = st_log.size() > s0; end
    chk_i("rstw_started", int'(got), 1);
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk_i("rstw_ready", int'(bus.cmd_ready), 1);
    chk_i("rstw_flags", int'({bus.busy, bus.done, bus.err, bus.mul_start, bus.ram_a_w}), 0);
    chk_w("rstw_op_a", bus.mul_op_a, '0);
    chk_w("rstw_op_b", bus.mul_op_b, '0);
    chk_i("rstw_addr", int'({bus.ram_a_adbus, bus.ram_b_adbus}), 0);
    step();
    rst = 1'b0;
    repeat (6) step();
    chk_i("rstw_no_write", wr_log.size() - w0, 0);
    chk_i("rstw_no_done", done_log.size() - d0, 0);
    chk_i("rstw_idle", int'(bus.busy), 0);
    chk_ram("rstw");

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 3);
        ram[k] = rand_word();
        ref_mem[k] = ram[k];
      end
      sa = $urandom_range(0, 3);
      sb = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      lat = $urandom_range(0, TO + 2);
      stray = 1'($urandom_range(0, 1));
      run_cmd($sformatf("rnd%0d", n), sa, sb, d, lat, stray, (lat == 0) || (lat > TO));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
